// File: rtl/segments_scan_controller.sv
// Time-multiplexed scan controller for common-anode 7-segment digits on a shared segment bus.
// Frames arrive through a valid/ready handshake and take effect only at frame boundaries.
module segments_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [DIGITS-1:0]     load_mask,
  input  logic                  load_lzb,
  output logic [3:0]            digit_value,
  output logic                  digit_enable,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {
    PH_BLANK,
    PH_ON
  } phase_e;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   act_value;
  logic [DIGITS-1:0]     act_mask;
  logic                  act_lzb;
  logic                  pend;
  logic [4*DIGITS-1:0]   pend_value;
  logic [DIGITS-1:0]     pend_mask;
  logic                  pend_lzb;

  phase_e                phase;
  logic                  accept;
  logic                  last_slot;
  logic [DIGITS-1:0]     zero_from;
  logic                  lz;

  assign accept     = load_valid && load_ready;
  assign last_slot  = (cnt == CNT_LAST);
  assign load_ready = ~pend;
  assign frame_tick = last_slot && (idx == IDX_LAST);

  // NOTE: every state register uses non-blocking assignment so all flops
  // update together from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      act_value  <= '0;
      act_mask   <= '0;
      act_lzb    <= 1'b0;
      pend       <= 1'b0;
      pend_value <= '0;
      pend_mask  <= '0;
      pend_lzb   <= 1'b0;
    end else begin
      if (last_slot) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      // accept implies pend is clear, so commit and capture never collide;
      // a capture on the boundary cycle waits for the next boundary.
      if (frame_tick && pend) begin
        act_value <= pend_value;
        act_mask  <= pend_mask;
        act_lzb   <= pend_lzb;
        pend      <= 1'b0;
      end else if (accept) begin
        pend_value <= load_value;
        pend_mask  <= load_mask;
        pend_lzb   <= load_lzb;
        pend       <= 1'b1;
      end
    end
  end

  // zero_from[i] is set when nibbles i..DIGITS-1 of the active frame are all zero.
  always_comb begin
    logic run;
    // NOTE: defaults first so no path leaves a combinational output unassigned
    // (which would otherwise infer a latch).
    zero_from = '0;
    run       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run && (act_value[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end
  end

  assign lz    = act_lzb && (idx != '0) && zero_from[idx];
  assign phase = (cnt < CNT_BLANK) ? PH_BLANK : PH_ON;

  always_comb begin
    digit_value  = act_value[4*int'(idx) +: 4];
    anode        = '1;
    digit_enable = 1'b0;
    if (phase == PH_ON) begin
      anode[idx]   = 1'b0;
      digit_enable = act_mask[idx] && !lz;
    end
  end

endmodule

// File: tb/tb_segments_scan_controller.sv
// Directed bench for segments_scan_controller with DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Each frame is run cycle by cycle against hand-computed frame contents and enable patterns.
module tb_segments_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_mask;
  logic        load_lzb;
  logic [3:0]  digit_value;
  logic        digit_enable;
  logic [3:0]  anode;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit pend_m = 1'b0;

  segments_scan_controller #(
    .DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .load_mask(load_mask),
    .load_lzb(load_lzb),
    .digit_value(digit_value),
    .digit_enable(digit_enable),
    .anode(anode),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs ncyc cycles of a frame, checking every output against the expected
  // active contents v and per-digit enable pattern en; up to two loads offered.
  task automatic run_frame(input logic [15:0] v, input logic [3:0] en, input int ncyc,
                           input int la1, input logic [15:0] lv1, input logic [3:0] lm1, input logic ll1,
                           input int la2, input logic [15:0] lv2, input logic [3:0] lm2, input logic ll2);
    for (int i = 0; i < ncyc; i++) begin
      int          c;
      int          d;
      logic [3:0]  an_e;
      logic        en_e;
      c    = i % 8;
      d    = i / 8;
      an_e = 4'hF;
      en_e = 1'b0;
      if (c >= 2) begin
        an_e[d] = 1'b0;
        en_e    = en[d];
      end
      load_valid = 1'b0;
      load_value = 16'h0;
      load_mask  = 4'h0;
      load_lzb   = 1'b0;
      if (i == la1) begin
        load_valid = 1'b1; load_value = lv1; load_mask = lm1; load_lzb = ll1;
      end
      if (i == la2) begin
        load_valid = 1'b1; load_value = lv2; load_mask = lm2; load_lzb = ll2;
      end
      check("anode", anode, an_e);
      check("digit_value", digit_value, v[4*d +: 4]);
      check("digit_enable", digit_enable, en_e);
      check("frame_tick", frame_tick, i == 31);
      check("load_ready", load_ready, !pend_m);
      if (i == 31 && pend_m) pend_m = 1'b0;
      else if (load_valid && !pend_m) pend_m = 1'b1;
      step();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_value = 16'h0;
    load_mask  = 4'h0;
    load_lzb   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Frame 0: idle scan, load 1A3F at cycle 3, second offer at cycle 5 is ignored.
    run_frame(16'h0000, 4'b0000, 32, 3, 16'h1A3F, 4'hF, 1'b0, 5, 16'h5555, 4'h0, 1'b1);
    // Frame 1: 1A3F fully lit; load 0070 with leading-zero blanking.
    run_frame(16'h1A3F, 4'b1111, 32, 10, 16'h0070, 4'hF, 1'b1, -1, 16'h0, 4'h0, 1'b0);
    // Frame 2: digits 2,3 blanked as leading zeros; transfer on the frame_tick cycle.
    run_frame(16'h0070, 4'b0011, 32, 31, 16'h0000, 4'hF, 1'b1, -1, 16'h0, 4'h0, 1'b0);
    // Frame 3: boundary transfer not yet committed, previous frame repeats.
    run_frame(16'h0070, 4'b0011, 32, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    // Frame 4: all-zero with lzb, only digit 0 lit; load masked 8888.
    run_frame(16'h0000, 4'b0001, 32, 0, 16'h8888, 4'b1010, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    // Frame 5: mask 1010; load 1234 late in the frame.
    run_frame(16'h8888, 4'b1010, 32, 20, 16'h1234, 4'hF, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    // Frame 6 up to cycle 20 with BEEF pending, then reset.
    run_frame(16'h1234, 4'b1111, 20, 0, 16'hBEEF, 4'hF, 1'b1, -1, 16'h0, 4'h0, 1'b0);

    check("pending_before_reset", load_ready, 1'b0);
    reset = 1'b1;
    step();
    check("rst_anode", anode, 4'hF);
    check("rst_digit_enable", digit_enable, 1'b0);
    check("rst_digit_value", digit_value, 4'h0);
    check("rst_frame_tick", frame_tick, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    reset  = 1'b0;
    cyc    = 0;
    pend_m = 1'b0;

    // After reset: all-zero active data for two frames, BEEF never appears.
    run_frame(16'h0000, 4'b0000, 32, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);
    run_frame(16'h0000, 4'b0000, 32, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
